baby_beat_timing: RTL and testbench

Timing generator for the Baby TTL datapath: a bit-time counter, a four-beat instruction sequencer (SCAN1, ACTION1, SCAN2, ACTION2) and run/stop/single-step control. Its registered bit, beat and strobe outputs are the timing terms that downstream quad-AND gating (74LS08-style) combines with data lines to enable each serial transfer. It replaces hand-wired 74LS161/74LS74 timing with one verified block.

---
 rtl/baby_timing_pkg.sv | 20 ++
 rtl/ttl_rise_detect.sv | 30 +++
 rtl/baby_beat_timing.sv | 105 ++++++++++
 tb/tb_baby_beat_timing.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/baby_timing_pkg.sv
// Shared definitions for the Baby timing generator.
//   DEFAULT_WORD_BITS : serial word length used when the top is not overridden
//   BEAT_*            : beat codes presented on the BEAT output
//   ctrl_state_t      : run/stop/single-step control states
package baby_timing_pkg;

    localparam int DEFAULT_WORD_BITS = 32;

    localparam logic [1:0] BEAT_SCAN1   = 2'd0;
    localparam logic [1:0] BEAT_ACTION1 = 2'd1;
    localparam logic [1:0] BEAT_SCAN2   = 2'd2;
    localparam logic [1:0] BEAT_ACTION2 = 2'd3;

    typedef enum logic [1:0] {
        CTRL_STOPPED  = 2'd0,
        CTRL_RUNNING  = 2'd1,
        CTRL_STEPPING = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/ttl_rise_detect.sv
// Rising-edge detector for an already synchronised panel key.
//   clk   : system clock
//   rst   : synchronous active-high reset; loads prev with RESET_VAL
//   din   : key level
//   rise  : one-cycle pulse when din is high and was low on the previous cycle
// With RESET_VAL = 1 a key held down through reset does not register a press.
module ttl_rise_detect
    import baby_timing_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= RESET_VAL;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/baby_beat_timing.sv
// Timing generator for the Baby serial datapath.
//   CLK, RESET        : clock and synchronous active-high reset
//   RUN               : run/stop switch level
//   SINGLE_STEP       : step key level (edge-detected here)
//   HALT              : stop request from stop-instruction decode
//   BIT, BEAT         : current bit time and beat
//   SCAN1..ACTION2    : one-hot beat strobes, zero when stopped
//   ACTIVE, STOPPED   : control status (STOPPED drives the stop lamp)
//   WORD_START/END    : first/last bit time of a beat
//   INSTR_END         : last bit time of ACTION2
// All outputs decode registered state only, so they are glitch-safe timing
// terms for downstream AND gating.
module baby_beat_timing
    import baby_timing_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         RUN,
    input  logic                         SINGLE_STEP,
    input  logic                         HALT,
    output logic [$clog2(WORD_BITS)-1:0] BIT,
    output logic [1:0]                   BEAT,
    output logic                         SCAN1,
    output logic                         ACTION1,
    output logic                         SCAN2,
    output logic                         ACTION2,
    output logic                         ACTIVE,
    output logic                         WORD_START,
    output logic                         WORD_END,
    output logic                         INSTR_END,
    output logic                         STOPPED
);

    localparam int                BIT_W    = $clog2(WORD_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_BITS - 1);

    ctrl_state_t      state;
    logic [BIT_W-1:0] bit_cnt;
    logic [1:0]       beat_cnt;
    logic             step_rise;

    ttl_rise_detect #(
        .RESET_VAL (1'b1)
    ) u_step_rise (
        .clk  (CLK),
        .rst  (RESET),
        .din  (SINGLE_STEP),
        .rise (step_rise)
    );

    // RUN, HALT and step edges are only looked at in STOPPED and at the
    // instruction boundary; an instruction, once started, always completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= CTRL_STOPPED;
            bit_cnt  <= '0;
            beat_cnt <= BEAT_SCAN1;
        end else begin
            case (state)
                CTRL_STOPPED: begin
                    bit_cnt  <= '0;
                    beat_cnt <= BEAT_SCAN1;
                    // RUN has priority; a simultaneous step edge is dropped.
                    if (RUN) begin
                        state <= CTRL_RUNNING;
                    end else if (step_rise) begin
                        state <= CTRL_STEPPING;
                    end
                end
                CTRL_RUNNING, CTRL_STEPPING: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        beat_cnt <= beat_cnt + 2'd1;
                        if ((beat_cnt == BEAT_ACTION2) &&
                            ((state == CTRL_STEPPING) || !RUN || HALT)) begin
                            state <= CTRL_STOPPED;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= CTRL_STOPPED;
                    bit_cnt  <= '0;
                    beat_cnt <= BEAT_SCAN1;
                end
            endcase
        end
    end

    assign ACTIVE     = (state != CTRL_STOPPED);
    assign STOPPED    = (state == CTRL_STOPPED);
    assign BIT        = bit_cnt;
    assign BEAT       = beat_cnt;
    assign SCAN1      = ACTIVE && (beat_cnt == BEAT_SCAN1);
    assign ACTION1    = ACTIVE && (beat_cnt == BEAT_ACTION1);
    assign SCAN2      = ACTIVE && (beat_cnt == BEAT_SCAN2);
    assign ACTION2    = ACTIVE && (beat_cnt == BEAT_ACTION2);
    assign WORD_START = ACTIVE && (bit_cnt == '0);
    assign WORD_END   = ACTIVE && (bit_cnt == LAST_BIT);
    assign INSTR_END  = WORD_END && (beat_cnt == BEAT_ACTION2);

endmodule

// File: tb/tb_baby_beat_timing.sv
// Bench for baby_beat_timing: a 32-bit-word and a 4-bit-word instance share
// the same inputs; each is compared every cycle against a reference that
// tracks only the run mode and the position within the instruction.
module tb_baby_beat_timing;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic RUN = 1'b0;
    logic SINGLE_STEP = 1'b0;
    logic HALT = 1'b0;

    logic [4:0] bit32;
    logic [1:0] beat32;
    logic [3:0] strb32;
    logic act32, ws32, we32, ie32, stp32;

    logic [1:0] bit4;
    logic [1:0] beat4;
    logic [3:0] strb4;
    logic act4, ws4, we4, ie4, stp4;

    int n_cmp = 0;
    int n_err = 0;

    // mode: 0 stopped, 1 running, 2 stepping; idx: cycle within instruction
    typedef struct {
        int   mode;
        int   idx;
        logic prev;
    } mdl_t;

    mdl_t m32, m4;

    always #5 CLK = ~CLK;

    baby_beat_timing #(.WORD_BITS(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .SINGLE_STEP(SINGLE_STEP), .HALT(HALT),
        .BIT(bit32), .BEAT(beat32),
        .SCAN1(strb32[0]), .ACTION1(strb32[1]), .SCAN2(strb32[2]), .ACTION2(strb32[3]),
        .ACTIVE(act32), .WORD_START(ws32), .WORD_END(we32), .INSTR_END(ie32),
        .STOPPED(stp32)
    );

    baby_beat_timing #(.WORD_BITS(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .SINGLE_STEP(SINGLE_STEP), .HALT(HALT),
        .BIT(bit4), .BEAT(beat4),
        .SCAN1(strb4[0]), .ACTION1(strb4[1]), .SCAN2(strb4[2]), .ACTION2(strb4[3]),
        .ACTIVE(act4), .WORD_START(ws4), .WORD_END(we4), .INSTR_END(ie4),
        .STOPPED(stp4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_next(mdl_t m, int w, logic rst, logic run,
                                      logic step, logic halt);
        mdl_t n;
        logic edge_seen;
        n = m;
        edge_seen = step & ~m.prev;
        n.prev = step;
        if (rst) begin
            n.mode = 0;
            n.idx  = 0;
            n.prev = 1'b1;
        end else if (m.mode == 0) begin
            n.idx = 0;
            if (run) n.mode = 1;
            else if (edge_seen) n.mode = 2;
        end else if (m.idx == 4 * w - 1) begin
            n.idx = 0;
            if (m.mode == 2 || !run || halt) n.mode = 0;
        end else begin
            n.idx = m.idx + 1;
        end
        return n;
    endfunction

    task automatic check_dut(input string pfx, input int w, input mdl_t m,
                             input logic [31:0] bitv, input logic [31:0] beatv,
                             input logic [3:0] strb, input logic act, input logic ws,
                             input logic we, input logic ie, input logic stp);
        logic       e_act;
        int         e_bit, e_beat;
        logic [3:0] e_strb;
        e_act  = (m.mode != 0);
        e_bit  = e_act ? m.idx % w : 0;
        e_beat = e_act ? m.idx / w : 0;
        e_strb = e_act ? (4'b0001 << e_beat) : 4'b0000;
        chk({pfx, ".bit"},        bitv,  e_bit);
        chk({pfx, ".beat"},       beatv, e_beat);
        chk({pfx, ".strobes"},    {28'd0, strb}, {28'd0, e_strb});
        chk({pfx, ".active"},     {31'd0, act}, {31'd0, e_act});
        chk({pfx, ".word_start"}, {31'd0, ws},  {31'd0, e_act && e_bit == 0});
        chk({pfx, ".word_end"},   {31'd0, we},  {31'd0, e_act && e_bit == w - 1});
        chk({pfx, ".instr_end"},  {31'd0, ie},  {31'd0, e_act && m.idx == 4 * w - 1});
        chk({pfx, ".stopped"},    {31'd0, stp}, {31'd0, !e_act});
    endtask

    // One clock: model follows the inputs seen at the edge, outputs are
    // compared on the falling edge.
    task automatic tick();
        @(posedge CLK);
        m32 = mdl_next(m32, 32, RESET, RUN, SINGLE_STEP, HALT);
        m4  = mdl_next(m4,  4,  RESET, RUN, SINGLE_STEP, HALT);
        @(negedge CLK);
        check_dut("w32", 32, m32, {27'd0, bit32}, {30'd0, beat32}, strb32,
                  act32, ws32, we32, ie32, stp32);
        check_dut("w4", 4, m4, {30'd0, bit4}, {30'd0, beat4}, strb4,
                  act4, ws4, we4, ie4, stp4);
    endtask

    task automatic wait_idx32(input string tag, input int target, input int budget);
        int n = 0;
        while (!(m32.mode != 0 && m32.idx == target) && n < budget) begin
            tick();
            n++;
        end
        chk({"reach.", tag}, {31'd0, n < budget}, 32'd1);
    endtask

    task automatic wait_stopped(input string tag, input int budget);
        int n = 0;
        while (!(m32.mode == 0 && m4.mode == 0) && n < budget) begin
            tick();
            n++;
        end
        chk({"stop.", tag}, {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        int cnt[4];
        int len4, starts;
        logic last_act;
        m32 = '{mode: 0, idx: 0, prev: 1'b1};
        m4  = '{mode: 0, idx: 0, prev: 1'b1};

        // Reset with RUN and key held, then release with key still held
        RESET = 1'b1; RUN = 1'b1; SINGLE_STEP = 1'b1; HALT = 1'b0;
        tick(); tick();
        chk("rst.stopped", {31'd0, stp32}, 32'd1);
        chk("rst.bit", {27'd0, bit32}, 32'd0);
        chk("rst.strobes", {28'd0, strb32}, 32'd0);
        chk("rst.active", {31'd0, act32}, 32'd0);
        RESET = 1'b0; RUN = 1'b0;
        repeat (5) tick();
        chk("rst.no_step", {31'd0, stp4}, 32'd1);

        // Free run, one full instruction at 32 bits per beat
        SINGLE_STEP = 1'b0; RUN = 1'b1;
        tick();
        chk("run.word_start", {31'd0, ws32}, 32'd1);
        chk("run.scan1", {31'd0, strb32[0]}, 32'd1);
        for (int i = 0; i < 4; i++) cnt[i] = strb32[i] ? 1 : 0;
        repeat (127) begin
            tick();
            for (int i = 0; i < 4; i++) if (strb32[i]) cnt[i]++;
        end
        chk("run.instr_end127", {31'd0, ie32}, 32'd1);
        for (int i = 0; i < 4; i++) chk("run.beat_len", cnt[i], 32);
        tick();
        chk("run.wrap_bit", {27'd0, bit32}, 32'd0);
        chk("run.wrap_scan1", {31'd0, strb32[0]}, 32'd1);

        // Graceful stop: RUN dropped at bit 5 of SCAN2
        wait_idx32("scan2_b5", 2 * 32 + 5, 300);
        RUN = 1'b0;
        wait_stopped("graceful", 300);
        chk("grace.beat", {30'd0, beat32}, 32'd0);

        // Single step with a second edge mid-step
        SINGLE_STEP = 1'b1;
        tick();
        SINGLE_STEP = 1'b0;
        len4 = act4 ? 1 : 0;
        for (int i = 0; i < 40 && act4; i++) begin
            SINGLE_STEP = (len4 == 6);
            tick();
            if (act4) len4++;
        end
        SINGLE_STEP = 1'b0;
        chk("step.len4", len4, 16);
        wait_stopped("step", 300);

        // Held key produces exactly one step
        SINGLE_STEP = 1'b1;
        starts = 0;
        last_act = 1'b0;
        repeat (60) begin
            tick();
            if (act4 && !last_act) starts++;
            last_act = act4;
        end
        chk("step.held_once", starts, 1);
        SINGLE_STEP = 1'b0;
        wait_stopped("held", 300);

        // HALT pulse in ACTION1, then HALT high at the instruction end
        RUN = 1'b1;
        wait_idx32("action1", 32 + 3, 300);
        HALT = 1'b1; tick(); HALT = 1'b0;
        wait_idx32("ie_a", 127, 300);
        HALT = 1'b1; tick();
        chk("halt.stop", {31'd0, stp32}, 32'd1);
        HALT = 1'b0;
        // HALT high only mid-instruction: no stop
        wait_idx32("mid", 64, 300);
        HALT = 1'b1; repeat (10) tick(); HALT = 1'b0;
        wait_idx32("ie_b", 127, 300);
        tick();
        chk("halt.no_stop", {31'd0, act32}, 32'd1);

        // Reset mid-instruction
        wait_idx32("a1_b17", 32 + 17, 300);
        RESET = 1'b1; tick();
        chk("rstmid.stopped", {31'd0, stp32}, 32'd1);
        chk("rstmid.bit", {27'd0, bit32}, 32'd0);
        RESET = 1'b0; RUN = 1'b0; SINGLE_STEP = 1'b0;
        tick();

        // RUN and step edge together: running wins, keeps going
        RUN = 1'b1; SINGLE_STEP = 1'b1; tick(); SINGLE_STEP = 1'b0;
        wait_idx32("sim_ie", 127, 300);
        tick();
        chk("sim.continues", {31'd0, act32}, 32'd1);

        // Randomised operation
        repeat (4000) begin
            RESET = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) RUN = ~RUN;
            if ($urandom_range(0, 7) == 0) SINGLE_STEP = ~SINGLE_STEP;
            HALT = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
